// File: rtl/stream_pattern_gen_if.sv
// Stream bus between the pattern generator (master) and its sink (slave).
// Handshake: a beat transfers on every rising clk edge where m_valid=1 and
// m_ready=1. Once m_valid is raised, m_valid, m_data and m_last hold steady
// until that transfer happens. m_valid never depends combinationally on m_ready.
interface stream_pattern_gen_if #(
    parameter int DATA_W = 32
);
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    modport master (output m_valid, output m_data, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/stream_pattern_gen.sv
// Packetised counting-pattern source: emits pkt_len beats of an incrementing
// counter, with optional idle cycles after each beat (rate_div) and between
// packets (gap_len). The counter runs on across packets; seed/clear reload it.
module stream_pattern_gen #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16,
    parameter int GAP_W  = 16,
    parameter int RATE_W = 5
) (
    input  logic                  clk,
    input  logic                  glbl_rst,
    input  logic                  enable,
    input  logic [LEN_W-1:0]      pkt_len,
    input  logic [GAP_W-1:0]      gap_len,
    input  logic [RATE_W-1:0]     rate_div,
    input  logic [DATA_W-1:0]     seed,
    input  logic                  clear,
    output logic [31:0]           pkt_count,
    output logic                  busy,
    output logic [1:0]            dbg_state,
    stream_pattern_gen_if.master  m
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [31:0]         pkt_q, pkt_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    beat_q, beat_d;
    logic [RATE_W-1:0]   rate_q, rate_d;
    logic [RATE_W-1:0]   rate_cnt_q, rate_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;

    logic                accept;
    logic                start;
    logic [LEN_W-1:0]    eff_len;

    assign accept    = valid_q & m.m_ready;
    // A zero length request still produces a one-beat packet.
    assign eff_len   = (pkt_len == '0) ? LEN_W'(1) : pkt_len;

    assign m.m_valid = valid_q;
    assign m.m_data  = data_q;
    assign m.m_last  = last_q;
    assign pkt_count = pkt_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

    // Next-state logic: packet sequencing, beat pacing and counter advance.
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        last_d     = last_q;
        data_d     = data_q;
        pkt_d      = pkt_q;
        len_d      = len_q;
        beat_d     = beat_q;
        rate_d     = rate_q;
        rate_cnt_d = rate_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        start      = 1'b0;

        case (state_q)
            IDLE: begin
                if (clear) data_d = seed;
                if (enable) start = 1'b1;
            end
            SEND: begin
                if (accept) begin
                    data_d = data_q + DATA_W'(1);
                    if (last_q) begin
                        pkt_d   = pkt_q + 32'd1;
                        beat_d  = '0;
                        last_d  = 1'b0;
                        valid_d = 1'b0;
                        if (gap_len != '0) begin
                            state_d   = GAP;
                            gap_cnt_d = gap_len;
                        end else if (enable) begin
                            start = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        beat_d = beat_q + LEN_W'(1);
                        if (rate_q == '0) begin
                            last_d = (beat_q + LEN_W'(1) == len_q - LEN_W'(1));
                        end else begin
                            valid_d    = 1'b0;
                            rate_cnt_d = rate_q;
                        end
                    end
                end else if (!valid_q) begin
                    // Pacing hole after a non-last beat; re-offer on its final cycle.
                    if (rate_cnt_q <= RATE_W'(1)) begin
                        rate_cnt_d = '0;
                        valid_d    = 1'b1;
                        last_d     = (beat_q == len_q - LEN_W'(1));
                    end else begin
                        rate_cnt_d = rate_cnt_q - RATE_W'(1);
                    end
                end
            end
            GAP: begin
                if (clear) data_d = seed;
                if (gap_cnt_q <= GAP_W'(1)) begin
                    gap_cnt_d = '0;
                    if (enable) start = 1'b1;
                    else        state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Packet start: sample length and pacing once, offer beat 0 next cycle.
        if (start) begin
            state_d    = SEND;
            valid_d    = 1'b1;
            len_d      = eff_len;
            rate_d     = rate_div;
            beat_d     = '0;
            rate_cnt_d = '0;
            last_d     = (eff_len == LEN_W'(1));
        end
    end

    // State register with synchronous reset that abandons any packet in flight.
    always_ff @(posedge clk) begin
        if (glbl_rst) begin
            state_q    <= IDLE;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            data_q     <= seed;
            pkt_q      <= '0;
            len_q      <= LEN_W'(1);
            beat_q     <= '0;
            rate_q     <= '0;
            rate_cnt_q <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            data_q     <= data_d;
            pkt_q      <= pkt_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            rate_q     <= rate_d;
            rate_cnt_q <= rate_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

endmodule

// File: tb/tb_stream_pattern_gen.sv
// Directed bench for stream_pattern_gen: a packet-level model checks every
// accepted beat, beat spacing, stall stability and the packet count, and each
// scenario pins a few hand-computed values.
module tb_stream_pattern_gen;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;
  localparam int GAP_W  = 16;
  localparam int RATE_W = 5;

  logic              clk = 1'b0;
  logic              glbl_rst;
  logic              enable;
  logic [LEN_W-1:0]  pkt_len;
  logic [GAP_W-1:0]  gap_len;
  logic [RATE_W-1:0] rate_div;
  logic [DATA_W-1:0] seed;
  logic              clear;
  logic [31:0]       pkt_count;
  logic              busy;
  logic [1:0]        dbg_state;

  stream_pattern_gen_if #(.DATA_W(DATA_W)) bus ();

  stream_pattern_gen #(
    .DATA_W(DATA_W), .LEN_W(LEN_W), .GAP_W(GAP_W), .RATE_W(RATE_W)
  ) dut (
    .clk(clk), .glbl_rst(glbl_rst), .enable(enable), .pkt_len(pkt_len),
    .gap_len(gap_len), .rate_div(rate_div), .seed(seed), .clear(clear),
    .pkt_count(pkt_count), .busy(busy), .dbg_state(dbg_state), .m(bus.master)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // scoreboard: log of accepted beats plus packet-level model state
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] got_q[$];
  logic              last_q[$];
  int                t_q[$];

  logic [DATA_W-1:0] md;
  int                idx = 0;
  int                mlen = 1;
  int                mrate = 0;
  logic [31:0]       mcnt = 0;
  int                idle_run = 0;
  int                exp_run = 0;
  bit                pend = 0;
  bit                gap_ph = 0;
  bit                hold = 0;
  logic [DATA_W-1:0] hd;
  logic              hl;

  // compare process: outputs are sampled on the falling edge
  always @(negedge clk) begin
    chk("pkt_count", {32'd0, pkt_count}, {32'd0, mcnt});
    if (glbl_rst) begin
      md = seed; idx = 0; mcnt = 0; pend = 0; hold = 0; gap_ph = 0; idle_run = 0;
    end else begin
      if (hold) begin
        chk("hold_valid", {63'd0, bus.m_valid}, 64'd1);
        chk("hold_data", {32'd0, bus.m_data}, {32'd0, hd});
        chk("hold_last", {63'd0, bus.m_last}, {63'd0, hl});
      end
      hold = bus.m_valid && !bus.m_ready;
      hd = bus.m_data;
      hl = bus.m_last;
      if (bus.m_valid && pend) begin
        chk("spacing", 64'(idle_run), 64'(exp_run));
        pend = 0;
      end
      if (bus.m_valid && bus.m_ready) begin
        if (idx == 0) begin
          mlen = (pkt_len == 0) ? 1 : int'(pkt_len);
          mrate = int'(rate_div);
        end
        exp_q.push_back(md);
        chk("beat_data", {32'd0, bus.m_data}, {32'd0, exp_q.pop_front()});
        chk("beat_last", {63'd0, bus.m_last}, {63'd0, (idx == mlen - 1)});
        got_q.push_back(bus.m_data);
        last_q.push_back(bus.m_last);
        t_q.push_back(cyc);
        md = md + 1;
        idle_run = 0;
        if (idx == mlen - 1) begin
          mcnt = mcnt + 1;
          idx = 0;
          exp_run = int'(gap_len);
          gap_ph = 1;
          pend = (gap_len != 0) || enable;
        end else begin
          idx++;
          exp_run = mrate;
          gap_ph = 0;
          pend = 1;
        end
      end else if (!bus.m_valid) begin
        idle_run++;
        if (gap_ph && !enable) pend = 0;
        if (clear && idx == 0) md = seed;
      end
    end
  end

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic [DATA_W-1:0] s);
    seed = s;
    glbl_rst = 1'b1;
    step(2);
    glbl_rst = 1'b0;
  endtask

  task automatic wait_acc(input int n, input int budget);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      step(1);
      k++;
    end
    checks++;
    if (got_q.size() < n) begin
      errors++;
      $display("FAIL wait_acc actual=%0d expected=%0d", got_q.size(), n);
    end
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((busy || bus.m_valid) && k < budget) begin
      step(1);
      k++;
    end
    checks++;
    if (busy || bus.m_valid) begin
      errors++;
      $display("FAIL wait_idle actual=busy%0d expected=busy0", busy);
    end
  endtask

  task automatic clr_log();
    got_q.delete();
    last_q.delete();
    t_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    glbl_rst = 1'b1; enable = 1'b0; pkt_len = 16'd4; gap_len = '0; rate_div = '0;
    seed = '0; clear = 1'b0; bus.m_ready = 1'b1;
    do_reset(32'h0);

    // reset state
    chk("rst_valid", {63'd0, bus.m_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_count", {32'd0, pkt_count}, 64'd0);
    chk("rst_data", {32'd0, bus.m_data}, 64'd0);

    // back-to-back packets of 4, 1-cycle start latency
    clr_log();
    enable = 1'b1;
    step(1);
    chk("latency_valid", {63'd0, bus.m_valid}, 64'd1);
    chk("latency_data", {32'd0, bus.m_data}, 64'd0);
    wait_acc(8, 50);
    chk("t1_count", {32'd0, pkt_count}, 64'd2);
    enable = 1'b0;
    for (int i = 0; i < 8; i++) chk("t1_data", {32'd0, got_q[i]}, 64'(i));
    chk("t1_last3", {63'd0, last_q[3]}, 64'd1);
    chk("t1_last2", {63'd0, last_q[2]}, 64'd0);
    chk("t1_last7", {63'd0, last_q[7]}, 64'd1);
    wait_idle(50);

    // reload from seed while idle, then stall the sink on data 2
    seed = 32'h0;
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    clr_log();
    enable = 1'b1;
    wait_acc(2, 50);
    bus.m_ready = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("stall_valid", {63'd0, bus.m_valid}, 64'd1);
      chk("stall_data", {32'd0, bus.m_data}, 64'd2);
      chk("stall_last", {63'd0, bus.m_last}, 64'd0);
    end
    bus.m_ready = 1'b1;
    wait_idle(50);
    chk("stall_beats", 64'(got_q.size()), 64'd4);
    chk("stall_b2", {32'd0, got_q[2]}, 64'd2);
    chk("stall_b3", {32'd0, got_q[3]}, 64'd3);

    // rate and gap spacing
    rate_div = 5'd3; gap_len = 16'd5; pkt_len = 16'd2;
    clr_log();
    enable = 1'b1;
    wait_acc(4, 100);
    enable = 1'b0;
    wait_idle(100);
    chk("rate_t1", 64'(t_q[1] - t_q[0]), 64'd4);
    chk("gap_t2", 64'(t_q[2] - t_q[1]), 64'd6);
    chk("rate_t3", 64'(t_q[3] - t_q[2]), 64'd4);
    rate_div = '0; gap_len = '0;

    // enable dropped mid-packet; length change and clear ignored mid-packet
    do_reset(32'h10);
    pkt_len = 16'd8;
    clr_log();
    enable = 1'b1;
    wait_acc(1, 50);
    pkt_len = 16'd2;
    wait_acc(3, 50);
    enable = 1'b0;
    seed = 32'hABC;
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    wait_idle(50);
    chk("drop_beats", 64'(got_q.size()), 64'd8);
    chk("drop_b3", {32'd0, got_q[3]}, 64'h13);
    chk("drop_b7", {32'd0, got_q[7]}, 64'h17);
    chk("drop_last7", {63'd0, last_q[7]}, 64'd1);
    chk("drop_last6", {63'd0, last_q[6]}, 64'd0);
    chk("drop_busy", {63'd0, busy}, 64'd0);
    chk("drop_count", {32'd0, pkt_count}, 64'd1);

    // wraparound with zero length
    do_reset(32'hFFFF_FFFF);
    pkt_len = 16'd0;
    clr_log();
    enable = 1'b1;
    wait_acc(2, 50);
    chk("wrap_count", {32'd0, pkt_count}, 64'd2);
    enable = 1'b0;
    wait_idle(50);
    chk("wrap_b0", {32'd0, got_q[0]}, 64'hFFFF_FFFF);
    chk("wrap_b1", {32'd0, got_q[1]}, 64'h0);
    chk("wrap_last0", {63'd0, last_q[0]}, 64'd1);
    chk("wrap_last1", {63'd0, last_q[1]}, 64'd1);

    // reset in the middle of a packet
    do_reset(32'h100);
    pkt_len = 16'd8;
    clr_log();
    enable = 1'b1;
    wait_acc(3, 50);
    glbl_rst = 1'b1;
    step(1);
    chk("mrst_valid", {63'd0, bus.m_valid}, 64'd0);
    chk("mrst_count", {32'd0, pkt_count}, 64'd0);
    chk("mrst_busy", {63'd0, busy}, 64'd0);
    glbl_rst = 1'b0;
    clr_log();
    wait_acc(1, 50);
    chk("mrst_first", {32'd0, got_q[0]}, 64'h100);
    enable = 1'b0;
    wait_idle(50);
    chk("mrst_beats", 64'(got_q.size()), 64'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
